// File: rtl/echo_timer.sv
// Ultrasonic ranging front end: issues the trigger pulse, times the echo in whole
// microseconds, and flags a missing or overlong echo before a re-trigger holdoff.
module echo_timer #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned HOLDOFF_US = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic [31:0] echo_time,
    output logic        e_done,
    output logic        i_idle,
    output logic        timeout
);

    localparam int unsigned DIV        = CLK_HZ / 1000000;
    localparam logic [31:0] DIV_LAST   = 32'(DIV - 1);
    localparam logic [31:0] TRIG_LIM   = 32'(TRIG_US);
    localparam logic [31:0] TOUT_LIM   = 32'(TIMEOUT_US);
    localparam logic [31:0] HOLD_LIM   = 32'(HOLDOFF_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE,
        HOLDOFF
    } state_t;

    state_t      state_q;
    logic        echo_m_q, echo_s_q, echo_d_q;
    logic [31:0] pre_q, us_q;
    logic        trig_q, e_done_q, i_idle_q, timeout_q;
    logic [31:0] echo_time_q;

    logic        tick_d, rise_d, fall_d;
    logic [31:0] pre_d, us_d;

    // us_d already includes the tick of the current cycle, so a fall on the last
    // clock of a microsecond reports that microsecond as complete.
    always_comb begin
        tick_d = (pre_q == DIV_LAST);
        pre_d  = tick_d ? '0 : pre_q + 32'd1;
        us_d   = (tick_d && (us_q != '1)) ? us_q + 32'd1 : us_q;
        rise_d = echo_s_q & ~echo_d_q;
        fall_d = ~echo_s_q & echo_d_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            echo_m_q    <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_d_q    <= 1'b0;
            pre_q       <= '0;
            us_q        <= '0;
            trig_q      <= 1'b0;
            e_done_q    <= 1'b0;
            i_idle_q    <= 1'b1;
            timeout_q   <= 1'b0;
            echo_time_q <= '0;
        end else begin
            echo_m_q <= echo;
            echo_s_q <= echo_m_q;
            echo_d_q <= echo_s_q;
            e_done_q <= 1'b0;
            pre_q    <= pre_d;
            us_q     <= us_d;

            // Every transition below also clears the prescaler and the us counter.
            case (state_q)
                IDLE: begin
                    pre_q <= '0;
                    us_q  <= '0;
                    if (start) begin
                        state_q  <= TRIG;
                        trig_q   <= 1'b1;
                        i_idle_q <= 1'b0;
                    end
                end
                TRIG: begin
                    if (us_d == TRIG_LIM) begin
                        state_q <= WAIT_RISE;
                        trig_q  <= 1'b0;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (rise_d) begin
                        state_q <= MEASURE;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end else if (us_d == TOUT_LIM) begin
                        state_q     <= DONE;
                        echo_time_q <= '0;
                        timeout_q   <= 1'b1;
                        e_done_q    <= 1'b1;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end
                MEASURE: begin
                    if (fall_d || (us_d == TOUT_LIM)) begin
                        state_q     <= DONE;
                        echo_time_q <= fall_d ? us_d : TOUT_LIM;
                        timeout_q   <= ~fall_d;
                        e_done_q    <= 1'b1;
                        pre_q       <= '0;
                        us_q        <= '0;
                    end
                end
                DONE: begin
                    state_q <= HOLDOFF;
                    pre_q   <= '0;
                    us_q    <= '0;
                end
                HOLDOFF: begin
                    if (us_d == HOLD_LIM) begin
                        state_q  <= IDLE;
                        i_idle_q <= 1'b1;
                        pre_q    <= '0;
                        us_q     <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    trig_q   <= 1'b0;
                    i_idle_q <= 1'b1;
                    pre_q    <= '0;
                    us_q     <= '0;
                end
            endcase
        end
    end

    assign trig      = trig_q;
    assign echo_time = echo_time_q;
    assign e_done    = e_done_q;
    assign i_idle    = i_idle_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_echo_timer.sv
// Directed bench for echo_timer, scaled to DIV=2 with short timeout and holdoff
// so every scenario fits in a short run.
module tb_echo_timer;

    localparam int unsigned CLK_HZ     = 2000000;
    localparam int unsigned TRIG_US    = 10;
    localparam int unsigned TIMEOUT_US = 1500;
    localparam int unsigned HOLDOFF_US = 300;

    logic        clk, rst, start, echo;
    logic        trig, e_done, i_idle, timeout;
    logic [31:0] echo_time;

    int unsigned errs, checks, cyc, done_cnt;

    echo_timer #(
        .CLK_HZ    (CLK_HZ),
        .TRIG_US   (TRIG_US),
        .TIMEOUT_US(TIMEOUT_US),
        .HOLDOFF_US(HOLDOFF_US)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .echo     (echo),
        .trig     (trig),
        .echo_time(echo_time),
        .e_done   (e_done),
        .i_idle   (i_idle),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial done_cnt = 0;
    always @(negedge clk) if (e_done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edone(input string tag, input int unsigned maxc);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (e_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int unsigned maxc);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (i_idle) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_trig_low(input string tag);
        logic seen;
        seen = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!trig) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int unsigned t0, n;

    initial begin
        errs = 0; checks = 0;
        rst = 1'b1; start = 1'b0; echo = 1'b0;
        #23;
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_time", echo_time, 32'd0);
        chk("rst_edone", 32'(e_done), 32'd0);
        chk("rst_tout", 32'(timeout), 32'd0);
        chk("rst_idle", 32'(i_idle), 32'd1);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);

        // A: trigger width and a normal 1160 us echo
        pulse_start();
        chk("a_idle_drop", 32'(i_idle), 32'd0);
        chk("a_trig_high", 32'(trig), 32'd1);
        n = 1;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!trig) break;
            n++;
        end
        chk("a_trig_clocks", n, 32'(TRIG_US * 2));
        chk("a_no_edone", done_cnt, 32'd0);
        repeat (200) @(negedge clk);
        echo = 1'b1;
        repeat (2320) @(negedge clk);
        echo = 1'b0;
        wait_edone("a_edone", 20);
        chk("a_time", echo_time, 32'd1160);
        chk("a_tout", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("a_edone_1cyc", 32'(e_done), 32'd0);
        wait_idle("a_idle", 700);
        chk("a_done_cnt", done_cnt, 32'd1);

        // B: no echo at all
        pulse_start();
        wait_trig_low("b_trig_low");
        t0 = cyc;
        wait_edone("b_edone", 3100);
        chk("b_wait_clocks", cyc - t0, 32'(TIMEOUT_US * 2));
        chk("b_time", echo_time, 32'd0);
        chk("b_tout", 32'(timeout), 32'd1);
        t0 = cyc;
        wait_idle("b_idle", 700);
        chk("b_holdoff_clocks", cyc - t0, 32'(HOLDOFF_US * 2 + 1));

        // C: echo longer than the timeout, falling during the holdoff
        pulse_start();
        wait_trig_low("c_trig_low");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        wait_edone("c_edone", 3100);
        chk("c_time", echo_time, 32'(TIMEOUT_US));
        chk("c_tout", 32'(timeout), 32'd1);
        repeat (380) @(negedge clk);
        chk("c_in_holdoff", 32'(i_idle), 32'd0);
        echo = 1'b0;
        wait_idle("c_idle", 700);
        chk("c_done_cnt", done_cnt, 32'd3);
        chk("c_time_hold", echo_time, 32'(TIMEOUT_US));

        // D: start pulses in TRIG, MEASURE and HOLDOFF are ignored; held start re-triggers
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_trig_low("d_trig_low");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (30) @(negedge clk);
        pulse_start();
        repeat (44) @(negedge clk);
        echo = 1'b0;
        wait_edone("d_edone", 20);
        chk("d_time", echo_time, 32'd37);
        chk("d_tout", 32'(timeout), 32'd0);
        @(negedge clk);
        start = 1'b1;
        wait_idle("d_idle", 700);
        chk("d_idle_trig", 32'(trig), 32'd0);
        @(negedge clk);
        chk("d_retrig_idle", 32'(i_idle), 32'd0);
        chk("d_retrig_trig", 32'(trig), 32'd1);
        start = 1'b0;
        chk("d_done_cnt", done_cnt, 32'd4);

        // E: asynchronous reset in the middle of a measurement
        wait_trig_low("e_trig_low");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("e_rst_trig", 32'(trig), 32'd0);
        chk("e_rst_idle", 32'(i_idle), 32'd1);
        chk("e_rst_time", echo_time, 32'd0);
        chk("e_rst_tout", 32'(timeout), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        echo = 1'b0;
        repeat (20) @(negedge clk);
        chk("e_no_edone", done_cnt, 32'd4);
        chk("e_still_idle", 32'(i_idle), 32'd1);
        pulse_start();
        wait_trig_low("e2_trig_low");
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        echo = 1'b0;
        wait_edone("e2_edone", 20);
        chk("e2_time", echo_time, 32'd25);
        chk("e2_tout", 32'(timeout), 32'd0);
        wait_idle("e2_idle", 700);
        chk("e2_done_cnt", done_cnt, 32'd5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
